mfp_ahb_eic: RTL

//  Parametrised External Interrupt Controller (EIC) for the m14k core in EIC mode.

---
 rtl/mfp_ahb_eic.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/mfp_ahb_eic.sv
// External Interrupt Controller for the m14k EIC mode, configured over AHB-Lite.
// Optional macro MFP_EIC_IRQ_SYNC_EN adds a 2-flop synchroniser ahead of IRQ sampling.
module mfp_ahb_eic #(
    parameter int          IRQ_CNT  = 32,
    parameter logic [3:0]  EIC_EISS = 4'h0
) (
    input  logic               SI_ClkIn,
    input  logic               SI_Reset,
    input  logic               HSEL,
    input  logic [31:0]        HADDR,
    input  logic [1:0]         HTRANS,
    input  logic               HWRITE,
    input  logic [31:0]        HWDATA,
    input  logic               HREADY,
    output logic [31:0]        HRDATA,
    output logic               HREADYOUT,
    output logic               HRESP,
    input  logic [IRQ_CNT-1:0] IRQ,
    input  logic               SI_IAck,
    input  logic [5:0]         SI_IVN,
    output logic               EIC_Present,
    output logic [7:0]         EIC_RIPL,
    output logic [5:0]         EIC_Vector,
    output logic [3:0]         EIC_EISS_o,
    output logic [16:0]        EIC_Offset
);

    localparam logic [2:0] A_EICR   = 3'd0;
    localparam logic [2:0] A_EIMSK  = 3'd1;
    localparam logic [2:0] A_EISMSK = 3'd2;
    localparam logic [2:0] A_EIFR   = 3'd3;
    localparam logic [2:0] A_EIFRC  = 3'd4;
    localparam logic [2:0] A_EIRAW  = 3'd5;

    logic [IRQ_CNT-1:0] irq_in;
    logic [IRQ_CNT-1:0] irq_s, irq_d;
    logic [IRQ_CNT-1:0] eimsk, eismsk, pending, pending_nx;
    logic [IRQ_CNT-1:0] clr, ack_clr, active;
    logic               eicr;
    logic [2:0]         addr_q;
    logic               wr_q;
    logic               we;
    logic               win_found;
    logic [5:0]         win_idx;
    logic               unused_ok;

    assign unused_ok = ^{HADDR[31:5], HADDR[1:0], HTRANS[0], HWDATA};

`ifdef MFP_EIC_IRQ_SYNC_EN
    logic [IRQ_CNT-1:0] sync1, sync2;

    always_ff @(posedge SI_ClkIn) begin
        if (SI_Reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= IRQ;
            sync2 <= sync1;
        end
    end

    assign irq_in = sync2;
`else
    assign irq_in = IRQ;
`endif

    assign HREADYOUT   = 1'b1;
    assign HRESP       = 1'b0;
    assign EIC_Present = 1'b1;
    assign EIC_EISS_o  = EIC_EISS;

    // Zero-wait slave: the registered write always completes on the following edge.
    always_ff @(posedge SI_ClkIn) begin
        if (SI_Reset) begin
            addr_q <= '0;
            wr_q   <= 1'b0;
        end else if (HSEL && HTRANS[1] && HREADY) begin
            addr_q <= HADDR[4:2];
            wr_q   <= HWRITE;
        end else begin
            wr_q   <= 1'b0;
        end
    end

    assign we = wr_q;

    always_comb begin
        ack_clr = '0;
        for (int unsigned i = 0; i < IRQ_CNT; i++) begin
            if (SI_IAck && (SI_IVN == 6'(i)))
                ack_clr[i] = 1'b1;
        end
        clr = ack_clr;
        if (we && (addr_q == A_EIFRC))
            clr = clr | HWDATA[IRQ_CNT-1:0];
        // Edge channels: set dominates clear; level channels track the sampled line.
        pending_nx = (eismsk & ((irq_s & ~irq_d) | (pending & ~clr)))
                   | (~eismsk & irq_s);
    end

    always_ff @(posedge SI_ClkIn) begin
        if (SI_Reset) begin
            irq_s   <= '0;
            irq_d   <= '0;
            pending <= '0;
            eicr    <= 1'b0;
            eimsk   <= '0;
            eismsk  <= '0;
        end else begin
            irq_s   <= irq_in;
            irq_d   <= irq_s;
            pending <= pending_nx;
            if (we && (addr_q == A_EICR))   eicr   <= HWDATA[0];
            if (we && (addr_q == A_EIMSK))  eimsk  <= HWDATA[IRQ_CNT-1:0];
            if (we && (addr_q == A_EISMSK)) eismsk <= HWDATA[IRQ_CNT-1:0];
        end
    end

    assign active = pending & eimsk & {IRQ_CNT{eicr}};

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned i = 0; i < IRQ_CNT; i++) begin
            if (active[i]) begin
                win_found = 1'b1;
                win_idx   = 6'(i);
            end
        end
    end

    always_ff @(posedge SI_ClkIn) begin
        if (SI_Reset) begin
            EIC_RIPL   <= '0;
            EIC_Vector <= '0;
            EIC_Offset <= '0;
        end else if (win_found) begin
            EIC_RIPL   <= 8'(win_idx) + 8'd1;
            EIC_Vector <= win_idx;
            EIC_Offset <= 17'h100 + (17'(win_idx) << 5);
        end else begin
            EIC_RIPL   <= '0;
            EIC_Vector <= '0;
            EIC_Offset <= '0;
        end
    end

    function automatic logic [31:0] pad(input logic [IRQ_CNT-1:0] v);
        logic [31:0] r;
        r = '0;
        r[IRQ_CNT-1:0] = v;
        return r;
    endfunction

    always_comb begin
        HRDATA = '0;
        case (addr_q)
            A_EICR:   HRDATA[0] = eicr;
            A_EIMSK:  HRDATA = pad(eimsk);
            A_EISMSK: HRDATA = pad(eismsk);
            A_EIFR:   HRDATA = pad(pending);
            A_EIRAW:  HRDATA = pad(irq_s);
            default:  HRDATA = '0;
        endcase
    end

endmodule
